sprite_palette_writer: RTL and testbench
========================================

Name: sprite_palette_writer

Overview:
- Loads sprite pixel RAM (19-bit address, 3-bit colour code per word) from a 24-bit RGB pixel stream; inverse of the sprite mapper path (code -> RGB).
- Quantises each incoming RGB pixel to the fixed 8-entry sprite palette and drives the RAM write port (write_address / data_In / we).
- Sits between a host/ROM-streaming source and the sprite RAM, and runs before the mapper begins reads.

Parameters:
- ADDR_W, 19, RAM address width.
- PIX_COUNT, 4096, pixels per load; legal range 1..2^ADDR_W.
- MISS_W, 16, width of miss counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy=1.
- base_addr  in  ADDR_W  first RAM address of the load; sampled when start is accepted.
- pix_valid  in  1  source has a pixel on pix_rgb.
- pix_rgb  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- pix_ready  out  1  block accepts pixel this cycle.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  3  RAM write data (colour code).
- wr_en  out  1  RAM write enable, one cycle per pixel.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last write has issued.
- miss_count  out  MISS_W  pixels in the current/last load with no exact palette match.

Behaviour:
- Reset: state=IDLE; pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, miss_count=0, pixel counter=0.
- Fixed palette: 1=091821, 2=5ac6ff, 3=295a7b, 4=4a9cd6, 5=091821, 6=3a7ba5, 7=183952. Code 0 is transparent.
- Encode (exact mode):
  - pix_rgb == ffffff or ececec -> code 0, not a miss.
  - Otherwise compare against entries 1..7; the lowest matching index wins, so 091821 -> 1, never 5.
  - No match -> code 0 and the pixel counts as a miss.
- States:
  - IDLE: busy=0, pix_ready=0. start=1 -> LOAD; latch base_addr; counter=0; miss_count=0.
  - LOAD: busy=1, pix_ready=1. A pixel is accepted on any edge with pix_valid & pix_ready. When the accept is for counter == PIX_COUNT-1 -> DRAIN.
  - DRAIN: pix_ready=0, busy=1. Stays until the final wr_en has issued, then -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Write latency: a pixel accepted at edge N produces wr_en=1 with wr_addr=base+index and wr_data=code during the cycle after edge N, so the RAM samples it at edge N+1.
  - wr_en is 0 in every cycle that has no matching accept.
  - Back-to-back accepts give a continuous wr_en.
- Address arithmetic: wr_addr = (base_addr + index) mod 2^ADDR_W; wraps silently past the top of memory.
- miss_count increments on a miss accept and saturates at all-ones. It holds its value after DONE until the next accepted start.
- pix_valid low in LOAD: stall with no write; the counter holds.
- start while busy=1: ignored, with no effect on base, counter or miss_count.
- Reset mid-load: immediate return to reset values; the partial load is abandoned and no done pulse is produced.
- PIX_COUNT=1: LOAD accepts one pixel -> DRAIN -> DONE.

Optional Feature:
- Macro: NEAREST_MATCH_EN.
- Defined:
  - Non-white pixels map to the palette entry 1..7 with minimum |dR|+|dG|+|dB| (10-bit sum); ties go to the lowest index.
  - Adds one pipeline register, so write latency becomes 2 cycles (accept at edge N -> wr_en during the cycle after edge N+1). DRAIN waits for both pipeline stages to empty.
  - miss_count counts pixels with nonzero minimum distance.
- Undefined: exact-match behaviour as above, with 1-cycle latency.

Test Plan:
- Reset, then start with base_addr=0x00100, PIX_COUNT=4, stream ececec, 5ac6ff, 183952, 091821 with pix_valid held high -> writes (0x00100,0), (0x00101,2), (0x00102,7), (0x00103,1) on consecutive cycles; one done pulse; miss_count=0.
- Stream 123456 and ffffff -> wr_data=0 for both; miss_count=1 (exact mode). With NEAREST_MATCH_EN, 123456 -> code 7, miss_count=1, and wr_en appears 2 cycles after accept.
- base_addr=0x7FFFE, PIX_COUNT=4 -> wr_addr sequence 7FFFE, 7FFFF, 00000, 00001.
- Toggle pix_valid 1,0,0,1 during LOAD -> exactly 2 writes at consecutive addresses; no wr_en in stall cycles; pix_ready stays 1.
- Assert start again mid-load, then assert Reset after the 2nd accept -> the second start has no effect; after Reset all outputs are 0, no done pulse; a fresh start restarts at the new base with miss_count=0.
- Feed 70000 unmatched pixels (PIX_COUNT=70000) -> miss_count saturates at 0xFFFF.

Source files
------------

// File: rtl/sprite_palette_writer.sv
// sprite_palette_writer
//   Streams 24-bit RGB pixels into sprite pixel RAM as 3-bit palette codes.
//   Each pixel becomes one RAM write at base_addr + index. The address wraps
//   modulo 2^ADDR_W. Pixels with no palette match are counted in miss_count.
//
// Optional build macro: NEAREST_MATCH_EN
//   Undefined (default): exact palette match. A pixel accepted at edge N is
//     written in the cycle that follows edge N.
//   Defined: nearest palette entry by L1 RGB distance. An extra pipeline
//     register moves the write to the cycle that follows edge N+1.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   start, base_addr    begin a load at base_addr; start is ignored unless idle
//   pix_valid/pix_rgb   pixel source; pix_ready is high for the whole LOAD state
//   wr_addr/wr_data/wr_en  RAM write port (registered)
//   busy, done          load in progress / one-cycle completion pulse
//   miss_count          saturating count of unmatched pixels in the current/last load
module sprite_palette_writer #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned PIX_COUNT = 4096,
    parameter int unsigned MISS_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pix_valid,
    input  logic [23:0]       pix_rgb,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [MISS_W-1:0] miss_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    // One extra bit so that PIX_COUNT = 2^ADDR_W still fits.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(PIX_COUNT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_q;
    logic [MISS_W-1:0] miss_q;
    logic              ready_q, busy_q, done_q, wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [2:0]        wr_data_q;

    // Entry 5 duplicates entry 1, so entry 5 can never win.
    function automatic logic [23:0] pal(input logic [2:0] idx);
        case (idx)
            3'd1:    pal = 24'h091821;
            3'd2:    pal = 24'h5ac6ff;
            3'd3:    pal = 24'h295a7b;
            3'd4:    pal = 24'h4a9cd6;
            3'd5:    pal = 24'h091821;
            3'd6:    pal = 24'h3a7ba5;
            3'd7:    pal = 24'h183952;
            default: pal = 24'h000000;
        endcase
    endfunction

    logic              accept;
    logic [ADDR_W-1:0] cur_addr;
    logic              enc_valid;
    logic [23:0]       enc_rgb;
    logic [ADDR_W-1:0] enc_addr;
    logic [3:0]        enc_res;    // {miss, code}
    logic              pending;    // a pixel is still inside the encode pipeline

    assign accept   = (state_q == StLoad) && pix_valid;
    assign cur_addr = base_q + cnt_q[ADDR_W-1:0];

`ifdef NEAREST_MATCH_EN
    logic              s1_valid_q;
    logic [23:0]       s1_rgb_q;
    logic [ADDR_W-1:0] s1_addr_q;

    function automatic logic [9:0] absd(input logic [7:0] a, input logic [7:0] b);
        absd = (a > b) ? {2'b00, a - b} : {2'b00, b - a};
    endfunction

    function automatic logic [3:0] encode(input logic [23:0] rgb);
        logic [9:0]  best;
        logic [9:0]  dist;
        logic [2:0]  code;
        logic [23:0] p;
        best = '1;
        code = 3'd1;
        if (rgb == 24'hffffff || rgb == 24'hececec) return 4'b0000;
        for (int i = 1; i < 8; i++) begin
            p    = pal(3'(i));
            dist = absd(rgb[23:16], p[23:16]) + absd(rgb[15:8], p[15:8])
                 + absd(rgb[7:0], p[7:0]);
            // Strict compare keeps the lowest index on ties.
            if (dist < best) begin
                best = dist;
                code = 3'(i);
            end
        end
        return {best != 10'd0, code};
    endfunction

    assign enc_valid = s1_valid_q;
    assign enc_rgb   = s1_rgb_q;
    assign enc_addr  = s1_addr_q;
    assign pending   = s1_valid_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_rgb_q  <= pix_rgb;
                s1_addr_q <= cur_addr;
            end
        end
    end
`else
    function automatic logic [3:0] encode(input logic [23:0] rgb);
        logic [2:0] code;
        logic       hit;
        code = '0;
        hit  = 1'b0;
        if (rgb == 24'hffffff || rgb == 24'hececec) return 4'b0000;
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = 7; i >= 1; i--) begin
            if (rgb == pal(3'(i))) begin
                code = 3'(i);
                hit  = 1'b1;
            end
        end
        return {~hit, code};
    endfunction

    assign enc_valid = accept;
    assign enc_rgb   = pix_rgb;
    assign enc_addr  = cur_addr;
    assign pending   = 1'b0;
`endif

    assign enc_res = encode(enc_rgb);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            cnt_q     <= '0;
            miss_q    <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= enc_valid;
            if (enc_valid) begin
                wr_addr_q <= enc_addr;
                wr_data_q <= enc_res[2:0];
                if (enc_res[3] && miss_q != '1) miss_q <= miss_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        base_q  <= base_addr;
                        cnt_q   <= '0;
                        miss_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastIdx) begin
                            state_q <= StDrain;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    // The output register holds the final write this cycle.
                    if (!pending) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pix_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_sprite_palette_writer.sv
// Testbench for sprite_palette_writer: directed loads with randomized pixels,
// checked every cycle against a behavioural write/miss model.
module tb_sprite_palette_writer;

    localparam int AW   = 19;
    localparam int PIXN = 4;
    localparam int BIGN = 70000;
`ifdef NEAREST_MATCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [23:0] PAL [8] = '{24'h000000, 24'h091821, 24'h5ac6ff, 24'h295a7b,
                                        24'h4a9cd6, 24'h091821, 24'h3a7ba5, 24'h183952};

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          pix_valid = 1'b0;
    logic [23:0]   pix_rgb = '0;
    logic          pix_ready, wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic [15:0]   miss_count;

    logic          b_start = 1'b0;
    logic [AW-1:0] b_base = '0;
    logic          b_valid = 1'b0;
    logic [23:0]   b_rgb = '0;
    logic          b_ready, b_wr_en, b_busy, b_done;
    logic [AW-1:0] b_wr_addr;
    logic [2:0]    b_wr_data;
    logic [15:0]   b_miss;

    sprite_palette_writer #(.ADDR_W(AW), .PIX_COUNT(PIXN), .MISS_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
        .done(done), .miss_count(miss_count)
    );

    sprite_palette_writer #(.ADDR_W(AW), .PIX_COUNT(BIGN), .MISS_W(16)) dut_big (
        .Clk(Clk), .Reset(Reset), .start(b_start), .base_addr(b_base),
        .pix_valid(b_valid), .pix_rgb(b_rgb), .pix_ready(b_ready),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_en(b_wr_en), .busy(b_busy),
        .done(b_done), .miss_count(b_miss)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [2:0]    code;
        bit            miss;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    bit   m_loading = 1'b0;
    int   m_last_due = -1;
    int   m_done_cyc = -1;
    int   m_base = 0;
    int   m_idx = 0;
    int   m_miss = 0;
    logic [23:0] pix_q [PIXN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Palette quantisation straight from the colour table.
    function automatic void ref_encode(input logic [23:0] rgb, output int code, output bit miss);
        logic [23:0] p;
        int best, d;
        code = 0;
        miss = 1'b0;
        if (rgb == 24'hffffff || rgb == 24'hececec) return;
`ifdef NEAREST_MATCH_EN
        best = 1 << 30;
        for (int i = 1; i < 8; i++) begin
            p = PAL[i];
            d = absdiff(int'(rgb[23:16]), int'(p[23:16])) + absdiff(int'(rgb[15:8]), int'(p[15:8]))
              + absdiff(int'(rgb[7:0]), int'(p[7:0]));
            if (d < best) begin
                best = d;
                code = i;
            end
        end
        miss = (best != 0);
`else
        for (int i = 1; i < 8; i++) begin
            p = PAL[i];
            if (rgb == p) begin
                code = i;
                return;
            end
        end
        miss = 1'b1;
`endif
    endfunction

    function automatic logic [23:0] rand_pix();
        int r;
        logic [23:0] p;
        r = $urandom_range(0, 3);
        if (r < 2) p = PAL[$urandom_range(1, 7)];
        else if (r == 2) p = 24'($urandom);
        else p = ($urandom_range(0, 1) == 1) ? 24'hffffff : 24'hececec;
        return p;
    endfunction

    function automatic logic [23:0] rand_unmatched();
        logic [23:0] p;
        int code;
        bit miss;
        do begin
            p = 24'($urandom);
            ref_encode(p, code, miss);
        end while (!miss);
        return p;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        #2;
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        exp_q.delete();
        m_loading = 1'b0;
        m_last_due = -1;
        m_done_cyc = -1;
        m_miss = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc++;
    endtask

    // Drives one cycle, checks every output, then advances the model.
    task automatic tick(input logic s, input logic v, input logic [23:0] rgb, output bit acc);
        wr_t w;
        bit  idle, miss;
        int  code;
        start = s;
        pix_valid = v;
        pix_rgb = rgb;
        @(negedge Clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            w = exp_q.pop_front();
            if (w.miss) m_miss = (m_miss == 65535) ? 65535 : m_miss + 1;
            chk("wr_en", 32'(wr_en), 32'd1);
            chk("wr_addr", 32'(wr_addr), 32'(w.addr));
            chk("wr_data", 32'(wr_data), 32'(w.code));
        end else begin
            chk("wr_en_quiet", 32'(wr_en), 32'd0);
        end
        chk("pix_ready", 32'(pix_ready), 32'(m_loading));
        chk("busy", 32'(busy), 32'(m_loading || cyc <= m_last_due));
        chk("done", 32'(done), 32'(cyc == m_done_cyc));
        chk("miss_count", 32'(miss_count), 32'(m_miss));

        acc = 1'b0;
        idle = !m_loading && (cyc > m_last_due) && (cyc != m_done_cyc);
        if (m_loading && v) begin
            ref_encode(rgb, code, miss);
            w.due  = cyc + LAT;
            w.addr = AW'((m_base + m_idx) % (1 << AW));
            w.code = 3'(code);
            w.miss = miss;
            exp_q.push_back(w);
            acc = 1'b1;
            if (m_idx == PIXN - 1) begin
                m_loading = 1'b0;
                m_last_due = cyc + LAT;
                m_done_cyc = cyc + LAT + 1;
            end else begin
                m_idx++;
            end
        end else if (idle && s) begin
            m_loading = 1'b1;
            m_base = int'(base_addr);
            m_idx = 0;
            m_miss = 0;
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // vmode: 0 valid held high, 1 random valid, 2 pattern 1,0,0,1 then high.
    task automatic run_load(input logic [AW-1:0] base, input int vmode,
                            input int restart_at, input int reset_at);
        bit   acc;
        int   k, guard;
        logic v, s;
        k = 0;
        guard = 0;
        base_addr = base;
        tick(1'b1, 1'b0, 24'h0, acc);
        base_addr = AW'($urandom);
        while (k < PIXN && guard < 64) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 1) == 1);
                default: v = !(guard == 1 || guard == 2);
            endcase
            s = (guard == restart_at);
            tick(s, v, v ? pix_q[k] : 24'($urandom), acc);
            if (acc) k++;
            guard++;
            if (reset_at > 0 && k == reset_at) begin
                do_reset();
                return;
            end
        end
        chk("load_bound", 32'(k), 32'(PIXN));
        repeat (LAT + 3) tick(1'b0, 1'b0, 24'h0, acc);
        chk("idle_after_load", 32'(busy), 32'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #1;
        do_reset();

        pix_q = '{24'hececec, 24'h5ac6ff, 24'h183952, 24'h091821};
        run_load(19'h00100, 0, -1, -1);
        chk("t1_miss", 32'(miss_count), 32'd0);

        pix_q = '{24'h123456, 24'hffffff, 24'h4a9cd6, 24'h3a7ba5};
        run_load(AW'($urandom), 0, -1, -1);
        chk("t2_miss", 32'(miss_count), 32'd1);

        for (int i = 0; i < PIXN; i++) pix_q[i] = rand_pix();
        run_load(19'h7fffe, 0, -1, -1);

        for (int i = 0; i < PIXN; i++) pix_q[i] = rand_pix();
        run_load(AW'($urandom), 2, -1, -1);

        // Restart attempt mid-load, then reset after the second accept.
        for (int i = 0; i < PIXN; i++) pix_q[i] = rand_unmatched();
        run_load(AW'($urandom), 0, 1, 2);

        for (int i = 0; i < PIXN; i++) pix_q[i] = rand_pix();
        run_load(19'h01234, 1, -1, -1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < PIXN; i++) pix_q[i] = rand_pix();
            run_load(AW'($urandom), t % 3, (t == 4) ? 2 : -1, -1);
        end

        // Long load to drive miss_count into saturation.
        b_base = AW'($urandom);
        b_start = 1'b1;
        @(posedge Clk);
        #1;
        b_start = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < BIGN; i++) begin
            b_rgb = rand_unmatched();
            if (i == 1000) begin
                @(negedge Clk);
                chk("big_ready", 32'(b_ready), 32'd1);
                chk("big_miss_1000", 32'(b_miss), 32'(1000 - (LAT - 1)));
            end
            @(posedge Clk);
            #1;
        end
        b_valid = 1'b0;
        seen = 0;
        repeat (LAT + 6) begin
            @(negedge Clk);
            if (b_done) seen++;
        end
        chk("big_done_pulses", 32'(seen), 32'd1);
        chk("big_miss_sat", 32'(b_miss), 32'h0000ffff);
        chk("big_busy_end", 32'(b_busy), 32'd0);
        chk("big_ready_end", 32'(b_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
